// File: rtl/hci_hwpe_load_sequencer_pkg.sv
// rtl/hci_hwpe_load_sequencer_pkg.sv - shared types and constants for the wide-port load sequencer
package hci_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } hci_load_seq_state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [15:0] len;
        logic [31:0] stride;
    } hci_load_cmd_t;

    localparam int HCI_LOAD_SEQ_MIN_DEPTH = 2;

endpackage

// File: rtl/hci_hwpe_load_sequencer_if.sv
// rtl/hci_hwpe_load_sequencer_if.sv - hci_core_intf wide TCDM request/response port
interface hci_core_intf #(
    parameter int DW = 128,
    parameter int AW = 32,
    parameter int UW = 1
) ();

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    logic [DW-1:0]   r_data;
    logic            r_valid;

    modport master (
        output req, add, wen, data, be, user,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, data, be, user,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hci_hwpe_load_sequencer_buf.sv
// rtl/hci_hwpe_load_sequencer_buf.sv - hci_load_seq_buf: registered response FIFO, no fall-through
module hci_load_seq_buf #(
    parameter int DW    = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              pop_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_wr;
    logic [IW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    wire w_push = push_i & ~clear_i;
    wire w_pop  = pop_i & (r_cnt != '0) & ~clear_i;
    wire w_full = (r_cnt == CW'(DEPTH));

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= next_ptr(r_wr);
            if (w_pop)  r_rd <= next_ptr(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; valid_o masks stale entries.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= push_data_i;
    end

    assign pop_data_o  = r_mem[r_rd];
    assign valid_o     = (r_cnt != '0);
    assign occupancy_o = r_cnt;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full));

endmodule

// File: rtl/hci_hwpe_load_sequencer.sv
// rtl/hci_hwpe_load_sequencer.sv - strided wide-load sequencer with credit-protected response buffer
// Optional stall counter: define HCI_LOAD_SEQ_PERF_EN.
module hci_hwpe_load_sequencer
    import hci_package::*;
#(
    parameter int DW    = 128,
    parameter int AW    = 32,
    parameter int LEN_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [AW-1:0]    cmd_base_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [AW-1:0]    cmd_stride_i,
    hci_core_intf.master     tcdm,
    output logic [DW-1:0]    data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      perf_stall_o
);

    // Depths below the minimum cannot hold an in-flight beat plus a buffered one.
    localparam int L_DEPTH = (DEPTH < HCI_LOAD_SEQ_MIN_DEPTH) ? HCI_LOAD_SEQ_MIN_DEPTH : DEPTH;
    localparam int CW      = $clog2(L_DEPTH + 1);

    hci_load_seq_state_e r_state;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_stride;
    logic [LEN_W-1:0]    r_remaining;
    logic [CW-1:0]       r_inflight;
    logic                r_discard;
    logic                r_done_zero;

    logic [CW-1:0]       w_occ;
    logic                w_buf_valid;

    // Credit uses registered occupancy only, so req never depends on data_ready_i.
    wire w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_occ}) < (CW + 1)'(L_DEPTH);
    wire w_accept    = cmd_valid_i & cmd_ready_o & ~clear_i;
    wire w_req       = (r_state == ISSUE) & w_credit_ok & ~clear_i;
    wire w_grant     = w_req & tcdm.gnt;
    wire w_rsp       = tcdm.r_valid & ~r_discard & ~clear_i;
    wire w_rsp_dec   = tcdm.r_valid & (r_inflight != '0);
    wire w_pop       = w_buf_valid & data_ready_i;
    wire w_last_pop  = (r_state == DRAIN) & (r_inflight == '0) & (w_occ == CW'(1)) & w_pop & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_inflight  <= '0;
            r_discard   <= 1'b0;
            r_done_zero <= 1'b0;
        end else if (clear_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= '0;
            r_discard   <= 1'b1;
            r_done_zero <= 1'b0;
        end else begin
            r_discard   <= 1'b0;
            r_done_zero <= 1'b0;
            r_inflight  <= r_inflight + CW'(w_grant) - CW'(w_rsp_dec);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= cmd_base_i;
                        r_stride    <= cmd_stride_i;
                        r_remaining <= cmd_len_i;
                        if (cmd_len_i == '0) r_done_zero <= 1'b1;
                        else                 r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_grant) begin
                        r_addr      <= r_addr + r_stride;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_W'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_pop) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    hci_load_seq_buf #(
        .DW    (DW),
        .DEPTH (L_DEPTH)
    ) i_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (w_rsp),
        .push_data_i (tcdm.r_data),
        .pop_i       (w_pop),
        .pop_data_o  (data_o),
        .valid_o     (w_buf_valid),
        .occupancy_o (w_occ)
    );

`ifdef HCI_LOAD_SEQ_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_stall <= '0;
        end else if (clear_i || w_accept) begin
            r_perf_stall <= '0;
        end else if ((r_state == ISSUE) && !w_credit_ok && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall_o = r_perf_stall;
`else
    assign perf_stall_o = '0;
`endif

    assign cmd_ready_o  = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done_zero | w_last_pop;
    assign data_valid_o = w_buf_valid;

    assign tcdm.req  = w_req;
    assign tcdm.add  = r_addr;
    assign tcdm.wen  = 1'b1;
    assign tcdm.be   = '1;
    assign tcdm.data = '0;
    assign tcdm.user = '0;

endmodule
